// File: rtl/nonce_reporter.sv
// Nonce return-path serializer: buffers found nonces in a FIFO and emits framed bytes.
// Optional macro NONCE_REPORT_CKSUM_EN appends an XOR checksum byte to each frame.
module nonce_reporter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   in,
    input  logic                          read,
    output logic [7:0]                    out,
    output logic                          write,
    input  logic                          ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_B3   = 3'd2,
        ST_B2   = 3'd3,
        ST_B1   = 3'd4,
        ST_B0   = 3'd5
`ifdef NONCE_REPORT_CKSUM_EN
        ,
        ST_CK   = 3'd6
`endif
    } state_t;

`ifdef NONCE_REPORT_CKSUM_EN
    function automatic logic [7:0] nonce_cksum(input logic [31:0] v);
        return v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
    endfunction
`endif

    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   hold_r;
    logic [7:0]    out_r;
    logic          write_r;
    logic          overflow_r;
    state_t        state_r;

    state_t        next_state_s;
    logic [7:0]    next_out_s;
    logic          next_write_s;
    logic          pop_s;
    logic          push_s;
    logic          xfer_s;
    logic          more_s;

    // A full FIFO refuses the nonce even if a pop frees a slot this cycle.
    assign push_s = read && (count_r < DEPTH_C);
    assign xfer_s = write_r && ready;
    assign more_s = (count_r != ZERO_C);

    assign out      = out_r;
    assign write    = write_r;
    assign overflow = overflow_r;
    assign count    = count_r;

    // Frame sequencing and the registered byte to present next cycle.
    always_comb begin
        next_state_s = state_r;
        next_out_s   = out_r;
        next_write_s = write_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (more_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_SYNC;
                    next_out_s   = SYNC_BYTE;
                    next_write_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (xfer_s) begin
                    next_state_s = ST_B3;
                    next_out_s   = hold_r[31:24];
                end else begin
                    next_state_s = ST_SYNC;
                end
            end
            ST_B3: begin
                if (xfer_s) begin
                    next_state_s = ST_B2;
                    next_out_s   = hold_r[23:16];
                end else begin
                    next_state_s = ST_B3;
                end
            end
            ST_B2: begin
                if (xfer_s) begin
                    next_state_s = ST_B1;
                    next_out_s   = hold_r[15:8];
                end else begin
                    next_state_s = ST_B2;
                end
            end
            ST_B1: begin
                if (xfer_s) begin
                    next_state_s = ST_B0;
                    next_out_s   = hold_r[7:0];
                end else begin
                    next_state_s = ST_B1;
                end
            end
`ifdef NONCE_REPORT_CKSUM_EN
            ST_B0: begin
                if (xfer_s) begin
                    next_state_s = ST_CK;
                    next_out_s   = nonce_cksum(hold_r);
                end else begin
                    next_state_s = ST_B0;
                end
            end
            ST_CK: begin
`else
            ST_B0: begin
`endif
                // Last byte: chain straight into the next frame when one is queued.
                if (xfer_s && more_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_SYNC;
                    next_out_s   = SYNC_BYTE;
                    next_write_s = 1'b1;
                end else if (xfer_s) begin
                    next_state_s = ST_IDLE;
                    next_out_s   = 8'h00;
                    next_write_s = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_out_s   = 8'h00;
                next_write_s = 1'b0;
            end
        endcase
    end

    // FSM, output, pointer, occupancy and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            out_r      <= 8'h00;
            write_r    <= 1'b0;
            overflow_r <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= ZERO_C;
            hold_r     <= 32'h0000_0000;
        end else begin
            state_r  <= next_state_s;
            out_r    <= next_out_s;
            write_r  <= next_write_s;
            if (read && !push_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                hold_r   <= mem_r[rd_ptr_r];
            end else begin
                rd_ptr_r <= rd_ptr_r;
                hold_r   <= hold_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in;
        end
    end

endmodule
